fifo_unpacker: RTL

FIFO_UNPACKER -- requirements
Module: fifo_unpacker

---
 rtl/fifo_unpacker_pkg.sv | 17 +
 rtl/fifo_unpacker_buf.sv | 58 +++++
 rtl/fifo_unpacker.sv | 101 ++++++++++
 3 files changed

// File: rtl/fifo_unpacker_pkg.sv
// Shared defaults, beat ratio and FSM encoding for the FIFO word unpacker.
package fifo_unpacker_pkg;
  localparam int DEF_IN_WIDTH  = 64;
  localparam int DEF_OUT_WIDTH = 16;
  localparam int DEF_BUF_DEPTH = 2;
  localparam int RATIO         = DEF_IN_WIDTH / DEF_OUT_WIDTH;

  typedef enum logic {
    EMPTY  = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // A counter still needs one bit when it only ever holds zero.
  function automatic int ctrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_unpacker_buf.sv
// Circular register buffer holding whole FIFO words until they are fully serialized.
module unpack_buf #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wrEn_i,
  input  logic [WIDTH-1:0]           wrData_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           headData_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;

  // Explicit wrap so depths that are not a power of two still work.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (wrEn_i) wrPtr_d = nextPtr(wrPtr_q);
    if (pop_i) rdPtr_d = nextPtr(rdPtr_q);
    case ({wrEn_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wrEn_i) mem_q[wrPtr_q] <= wrData_i;
  end

  assign headData_o = mem_q[rdPtr_q];
  assign count_o    = count_q;
endmodule

// File: rtl/fifo_unpacker.sv
// Reads wide words from a sync FIFO and streams them out as narrow beats, LSB slice first.
module fifo_unpacker
  import fifo_unpacker_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  output logic                 o_fifo_rden,
  input  logic                 i_fifo_vld,
  input  logic [IN_WIDTH-1:0]  i_fifo_data,
  input  logic                 i_fifo_underflow,
  output logic                 o_vld,
  input  logic                 i_rdy,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic                 o_last,
  output logic                 o_err,
  output logic                 o_busy
);
  localparam int NBEATS = IN_WIDTH / OUT_WIDTH;
  localparam int BW     = ctrWidth(NBEATS);
  localparam int CW     = $clog2(BUF_DEPTH + 1);
  localparam int OW     = CW + 1;

  state_e              state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic                rden_q, rden_d;
  logic                err_q, err_d;
  logic                inflight_q;
  logic                postRst_q;
  logic [CW-1:0]       count;
  logic [IN_WIDTH-1:0] headData;
  logic                full, vldSeen, wrEn, badVld;
  logic                lastBeat, accept, pop;
  logic [OW-1:0]       outstanding;

  unpack_buf #(
    .WIDTH(IN_WIDTH),
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .wrEn_i    (wrEn),
    .wrData_i  (i_fifo_data),
    .pop_i     (pop),
    .headData_o(headData),
    .count_o   (count)
  );

  // Data returning right after reset belongs to a read issued before it, so it is ignored.
  assign full     = (count == CW'(BUF_DEPTH));
  assign vldSeen  = i_fifo_vld && !postRst_q;
  assign wrEn     = vldSeen && inflight_q && !full;
  assign badVld   = vldSeen && (!inflight_q || full);
  assign lastBeat = (beat_q == BW'(NBEATS - 1));
  assign accept   = o_vld && i_rdy;
  assign pop      = accept && lastBeat;

  // A slot freed this cycle already counts as available for the next request.
  assign outstanding = OW'(count) - OW'(pop) + OW'(rden_q) + OW'(inflight_q);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    err_d   = err_q || badVld;
    rden_d  = !i_fifo_underflow && (outstanding < OW'(BUF_DEPTH));
    if (accept) beat_d = lastBeat ? '0 : beat_q + BW'(1);
    case (state_q)
      EMPTY:   if (wrEn) state_d = ACTIVE;
      ACTIVE:  if (pop && !wrEn && (count == CW'(1))) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= EMPTY;
      beat_q     <= '0;
      rden_q     <= 1'b0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
      postRst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      rden_q     <= rden_d;
      inflight_q <= rden_q;
      err_q      <= err_d;
      postRst_q  <= 1'b0;
    end
  end

  assign o_vld       = (state_q == ACTIVE);
  assign o_data      = o_vld ? headData[int'(beat_q)*OUT_WIDTH +: OUT_WIDTH] : '0;
  assign o_last      = o_vld && lastBeat;
  assign o_fifo_rden = rden_q;
  assign o_err       = err_q;
  assign o_busy      = (count != '0) || inflight_q;
endmodule
